ad_dac_spi_seq: RTL

Parametrised multi-channel DAC offload sequencer for the SPI engine. It buffers one DMA sample vector of `NUM_OF_CHANNELS` words. On each rate trigger it plays back a programmable table of up to `SEQ_DEPTH` channel writes as SPI engine command and SDO streams. It sits between the DMA/rate generator and the SPI engine interconnect, replacing fixed single-channel, fixed-width offload logic.

---
 rtl/ad_dac_spi_seq_pkg.sv | 18 +
 rtl/ad_dac_spi_seq_buf.sv | 62 ++++++
 rtl/ad_dac_spi_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ad_dac_spi_seq_pkg.sv
// rtl/ad_dac_spi_seq_pkg.sv - FSM states and SPI engine opcodes for the DAC offload sequencer
package ad_dac_spi_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CS_ON  = 3'd1;
    localparam state_t ST_XFER   = 3'd2;
    localparam state_t ST_SDO    = 3'd3;
    localparam state_t ST_CS_OFF = 3'd4;
    localparam state_t ST_SYNC   = 3'd5;

    localparam logic [7:0] OP_CS      = 8'h10;
    localparam logic [7:0] OP_XFER_WR = 8'h01;
    localparam logic [7:0] OP_SYNC    = 8'h30;
    localparam logic [7:0] CS_ALL_OFF = 8'hFF;

endpackage

// File: rtl/ad_dac_spi_seq_buf.sv
// rtl/ad_dac_spi_seq_buf.sv - DMA holding register, per-frame working copy and data byte mux
module ad_dac_spi_seq_buf
    import ad_dac_spi_seq_pkg::*;
#(
    parameter int NUM_OF_CHANNELS = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int CH_W            = 3,
    parameter int BW              = 2
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  dma_valid,
    output logic                                  dma_ready,
    input  logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] dma_data,
    input  logic                                  start,
    output logic                                  has_data,
    input  logic [CH_W-1:0]                       ch,
    input  logic [BW-1:0]                         byte_sel,
    output logic [7:0]                            data_byte
);

    localparam int NB = DATA_WIDTH / 8;

    logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] buf_q;
    logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] smp;
    logic                                  buf_full;

    assign dma_ready = ~buf_full;
    assign has_data  = buf_full | dma_valid;

    // An empty buffer receiving a beat on the start cycle feeds it straight into smp.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q    <= '0;
            smp      <= '0;
            buf_full <= 1'b0;
        end else if (start) begin
            if (buf_full) begin
                smp      <= buf_q;
                buf_full <= 1'b0;
            end else if (dma_valid) begin
                smp <= dma_data;
            end
        end else if (dma_valid && !buf_full) begin
            buf_q    <= dma_data;
            buf_full <= 1'b1;
        end
    end

    // byte_sel 1..NB walks the channel word MSB first; out-of-range channels read as zero.
    always_comb begin
        data_byte = 8'h00;
        for (int c = 0; c < NUM_OF_CHANNELS; c++) begin
            for (int k = 1; k <= NB; k++) begin
                if (ch == CH_W'(c) && byte_sel == BW'(k)) begin
                    data_byte = smp[c*DATA_WIDTH + DATA_WIDTH - 8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ad_dac_spi_seq.sv
// rtl/ad_dac_spi_seq.sv - table-driven multi-channel DAC offload sequencer for the SPI engine
module ad_dac_spi_seq
    import ad_dac_spi_seq_pkg::*;
#(
    parameter int         NUM_OF_CHANNELS = 8,
    parameter int         DATA_WIDTH      = 16,
    parameter int         SEQ_DEPTH       = 16,
    parameter logic [7:0] CS_MASK         = 8'hFE,
    localparam int        SEQ_W           = $clog2(SEQ_DEPTH),
    localparam int        CH_W            = (NUM_OF_CHANNELS > 1) ? $clog2(NUM_OF_CHANNELS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  enable,
    input  logic                                  trigger,
    input  logic                                  seq_wr_en,
    input  logic [SEQ_W-1:0]                      seq_wr_addr,
    input  logic [8+CH_W-1:0]                     seq_wr_data,
    input  logic [SEQ_W-1:0]                      seq_length,
    input  logic                                  dma_valid,
    output logic                                  dma_ready,
    input  logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] dma_data,
    output logic                                  cmd_valid,
    input  logic                                  cmd_ready,
    output logic [15:0]                           cmd_data,
    output logic                                  sdo_data_valid,
    input  logic                                  sdo_data_ready,
    output logic [7:0]                            sdo_data,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  underflow,
    output logic                                  overrun
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = $clog2(NB + 1);

    logic [8+CH_W-1:0] seq_tab [SEQ_DEPTH];
    logic [8+CH_W-1:0] nxt_ent_word;

    state_t            state, nxt_state;
    logic [SEQ_W-1:0]  entry, nxt_entry;
    logic [BW-1:0]     byte_idx, nxt_byte;
    logic [7:0]        frame_cnt;
    logic              start, sync_done, has_data;
    logic              cmd_hs, sdo_hs;
    logic [7:0]        buf_byte;
    logic              nxt_cmd_valid, nxt_sdo_valid;
    logic [15:0]       nxt_cmd_data;
    logic [7:0]        nxt_sdo_data;

    always_ff @(posedge clk) begin
        if (seq_wr_en) begin
            seq_tab[seq_wr_addr] <= seq_wr_data;
        end
    end

    assign nxt_ent_word = seq_tab[nxt_entry];
    assign cmd_hs       = cmd_valid & cmd_ready;
    assign sdo_hs       = sdo_data_valid & sdo_data_ready;

    always_comb begin
        nxt_state = state;
        nxt_entry = entry;
        nxt_byte  = byte_idx;
        start     = 1'b0;
        sync_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger && enable) begin
                    nxt_state = ST_CS_ON;
                    nxt_entry = '0;
                    start     = 1'b1;
                end
            end
            ST_CS_ON: if (cmd_hs) nxt_state = ST_XFER;
            ST_XFER: begin
                if (cmd_hs) begin
                    nxt_state = ST_SDO;
                    nxt_byte  = '0;
                end
            end
            ST_SDO: begin
                if (sdo_hs) begin
                    if (byte_idx == BW'(NB)) nxt_state = ST_CS_OFF;
                    else                     nxt_byte  = byte_idx + 1'b1;
                end
            end
            ST_CS_OFF: begin
                if (cmd_hs) begin
                    if (entry == seq_length) begin
                        nxt_state = ST_SYNC;
                    end else begin
                        nxt_state = ST_CS_ON;
                        nxt_entry = entry + 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (cmd_hs) begin
                    nxt_state = ST_IDLE;
                    sync_done = 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Stream outputs are registered from the next state so they hold steady while stalled.
    always_comb begin
        nxt_cmd_valid = 1'b0;
        nxt_cmd_data  = 16'h0000;
        nxt_sdo_valid = 1'b0;
        nxt_sdo_data  = 8'h00;
        case (nxt_state)
            ST_CS_ON: begin
                nxt_cmd_valid = 1'b1;
                nxt_cmd_data  = {OP_CS, CS_MASK};
            end
            ST_XFER: begin
                nxt_cmd_valid = 1'b1;
                nxt_cmd_data  = {OP_XFER_WR, 8'(NB)};
            end
            ST_SDO: begin
                nxt_sdo_valid = 1'b1;
                nxt_sdo_data  = (nxt_byte == '0) ? nxt_ent_word[7:0] : buf_byte;
            end
            ST_CS_OFF: begin
                nxt_cmd_valid = 1'b1;
                nxt_cmd_data  = {OP_CS, CS_ALL_OFF};
            end
            ST_SYNC: begin
                nxt_cmd_valid = 1'b1;
                nxt_cmd_data  = {OP_SYNC, frame_cnt};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            entry          <= '0;
            byte_idx       <= '0;
            frame_cnt      <= 8'h00;
            cmd_valid      <= 1'b0;
            cmd_data       <= 16'h0000;
            sdo_data_valid <= 1'b0;
            sdo_data       <= 8'h00;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            underflow      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= nxt_state;
            entry          <= nxt_entry;
            byte_idx       <= nxt_byte;
            cmd_valid      <= nxt_cmd_valid;
            cmd_data       <= nxt_cmd_data;
            sdo_data_valid <= nxt_sdo_valid;
            sdo_data       <= nxt_sdo_data;
            busy           <= (nxt_state != ST_IDLE);
            frame_done     <= sync_done;
            underflow      <= start & ~has_data;
            overrun        <= trigger & (state != ST_IDLE);
            if (sync_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    ad_dac_spi_seq_buf #(
        .NUM_OF_CHANNELS (NUM_OF_CHANNELS),
        .DATA_WIDTH      (DATA_WIDTH),
        .CH_W            (CH_W),
        .BW              (BW)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .dma_valid (dma_valid),
        .dma_ready (dma_ready),
        .dma_data  (dma_data),
        .start     (start),
        .has_data  (has_data),
        .ch        (nxt_ent_word[8 +: CH_W]),
        .byte_sel  (nxt_byte),
        .data_byte (buf_byte)
    );

endmodule
